// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between the execute stage and a simple word bus.
//
// One memory operation is accepted at a time and walked through the states
// IDLE -> REQ -> (WAIT) -> RESP. Stores place their data on the byte lanes
// selected by the address. Loads pull the addressed lane out of the returned
// word and sign- or zero-extend it. A misaligned access or an illegal size
// skips the bus completely and completes with o_fault.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_valid / o_req_ready request handshake from execute
//   i_addr, i_we, i_size,     effective address, store flag, access size
//   i_unsigned, i_wdata       (0 byte, 1 half, 2 word), zero-extend, store data
//   o_rsp_valid               one-cycle completion pulse
//   o_rdata, o_fault          extended load data and fault flag, valid with
//                             o_rsp_valid
//   o_mem_valid / i_mem_ready bus request handshake
//   o_mem_addr, o_mem_we,     word-aligned address, write enable,
//   o_mem_wstrb, o_mem_wdata  byte strobes, lane-placed write data
//   i_mem_rvalid, i_mem_rdata read return and full read word
// ---------------------------------------------------------------------------
module lsu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0] state;
  logic [1:0] addr_lo;
  logic [1:0] size_q;
  logic       uns_q;

  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: access_fault = 1'b0;
      SZ_HALF: access_fault = lo[0];
      SZ_WORD: access_fault = (lo != 2'b00);
      default: access_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: store_strb = 4'b0001 << lo;
      SZ_HALF: store_strb = 4'b0011 << lo;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Replicating the low-order data onto every lane lets the strobes alone
  // select which bytes the bus writes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: store_data = {4{wd[7:0]}};
      SZ_HALF: store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  assign o_req_ready = (state == IDLE);
  assign o_mem_valid = (state == REQ);
  assign o_rsp_valid = (state == RESP);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr_lo     <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      o_rdata     <= 32'h0;
      o_fault     <= 1'b0;
      o_mem_addr  <= 32'h0;
      o_mem_we    <= 1'b0;
      o_mem_wstrb <= 4'h0;
      o_mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            addr_lo <= i_addr[1:0];
            size_q  <= i_size;
            uns_q   <= i_unsigned;
            if (access_fault(i_size, i_addr[1:0])) begin
              // Faulting ops never touch the bus; the bus outputs keep
              // their previous values while o_mem_valid stays low.
              o_fault <= 1'b1;
              o_rdata <= 32'h0;
              state   <= RESP;
            end else begin
              o_fault     <= 1'b0;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_we    <= i_we;
              o_mem_wstrb <= i_we ? store_strb(i_size, i_addr[1:0]) : 4'h0;
              o_mem_wdata <= i_we ? store_data(i_size, i_wdata) : 32'h0;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            if (o_mem_we) begin
              o_rdata <= 32'h0;
              state   <= RESP;
            end else begin
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            o_rdata <= load_extract(i_mem_rdata, size_q, addr_lo, uns_q);
            state   <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have no parameters; all data/address widths SHALL equal the global XLEN (32).
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_req_valid  input  1  execute stage presents a memory op.
REQ-005 o_req_ready  output  1  block can accept a request.
REQ-006 i_addr  input  32  effective address (ALU ADD result).
REQ-007 i_we  input  1  1 = store, 0 = load.
REQ-008 i_size  input  2  0 byte, 1 half, 2 word, 3 illegal.
REQ-009 i_unsigned  input  1  load zero-extends when 1 (LBU/LHU).
REQ-010 i_wdata  input  32  store data, in low-order bits.
REQ-011 o_rsp_valid  output  1  one-cycle completion pulse.
REQ-012 o_rdata  output  32  extended load data, valid with o_rsp_valid.
REQ-013 o_fault  output  1  misaligned/illegal access, valid with o_rsp_valid.
REQ-014 o_mem_valid  output  1  bus request.
REQ-015 i_mem_ready  input  1  bus accepts request.
REQ-016 o_mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-017 o_mem_we / o_mem_wstrb / o_mem_wdata  output  1/4/32  write enable, byte strobes, lane-placed data.
REQ-018 i_mem_rvalid / i_mem_rdata  input  1/32  read return and full word.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-020 IDLE: o_req_ready=1; on i_req_valid, latch addr/we/size/unsigned/wdata; go REQ, or go RESP with fault if illegal.
REQ-021 Fault: size=3, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0; no bus access; o_rdata=0.
REQ-022 REQ: o_mem_valid=1 with stable addr/we/wstrb/wdata until i_mem_ready; on ready, store -> RESP, load -> WAIT.
REQ-023 WAIT: i_mem_rvalid SHALL be sampled only here; on rvalid capture extracted data and go RESP.
REQ-024 RESP: o_rsp_valid=1 for exactly one cycle, then IDLE; o_req_ready=0 in REQ, WAIT, RESP.
REQ-025 Latency: store with immediate ready, o_rsp_valid 2 cycles after accept; load with rvalid 1 cycle after ready, 3 cycles.
REQ-026 Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-027 Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-028 Load extract: select lane by addr[1:0]; byte/half sign-extend unless i_unsigned; word unchanged, i_unsigned ignored.
REQ-029 Loads SHALL drive o_mem_wstrb=0 and o_mem_we=0.
REQ-030 o_rdata SHALL be 0 for stores; it SHALL hold its value outside RESP.

Reset
REQ-031 With i_rst_n=0 at a rising edge, FSM SHALL enter IDLE; o_mem_valid, o_rsp_valid, o_fault, o_mem_we=0; o_rdata, o_mem_addr, o_mem_wdata, o_mem_wstrb=0.
REQ-032 Reset mid-transaction SHALL abandon it without o_rsp_valid; rvalid arriving afterwards SHALL be ignored.
REQ-033 o_req_ready SHALL be 1 the first cycle after reset deasserts.

Verification
REQ-034 Store word addr 0x1000, wdata 0xDEADBEEF, ready immediate -> mem_addr 0x1000, wstrb 1111, rsp 2 cycles after accept, fault 0.
REQ-035 Load byte addr 0x1003, mem word 0x80112233, signed -> o_rdata 0xFFFFFF80; same unsigned -> 0x00000080.
REQ-036 Store half addr 0x2002, wdata 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD.
REQ-037 Load word addr 0x1002 -> o_fault=1 at next-cycle rsp, o_mem_valid never asserts, o_rdata 0.
REQ-038 Load with i_mem_ready held low 5 cycles -> o_mem_valid/addr stable throughout; rsp after eventual rvalid.
REQ-039 Reset asserted in WAIT, rvalid arrives next cycle -> no o_rsp_valid, o_req_ready=1 after reset release.
